sponge_absorb: RTL and testbench
================================

SPONGE_ABSORB -- requirements
Module: sponge_absorb

Interface
REQ-001 Parameter: CWIDTH, 320, capacity width in bits.
REQ-002 Parameter: RWIDTH, 32, rate width in bits; also the message word width.
REQ-003 Parameter: REMAINWIDTH, 20, width of the message-length counter in bits.
REQ-004 Port: clk  input  1  rising-edge clock, the only clock.
REQ-005 Port: reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-006 Port: start  input  1  begin absorbing a new message; sampled in IDLE only.
REQ-007 Port: msg_len  input  REMAINWIDTH  total message length in bits; latched on an accepted start.
REQ-008 Port: in_data  input  RWIDTH  message word, LSB-first; a partial word uses bits [k-1:0].
REQ-009 Port: in_valid  input  1  in_data is valid.
REQ-010 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-011 Port: perm_go  output  1  permutation request, held until perm_done.
REQ-012 Port: perm_r_out  output  RWIDTH  rate sent to the permutation; equals the r register.
REQ-013 Port: perm_c_out  output  CWIDTH  capacity sent to the permutation; equals the c register.
REQ-014 Port: perm_r_in  input  RWIDTH  permuted rate.
REQ-015 Port: perm_c_in  input  CWIDTH  permuted capacity.
REQ-016 Port: perm_done  input  1  permutation result is valid.
REQ-017 Port: r  output  RWIDTH  absorbed rate, handed to the squeeze stage.
REQ-018 Port: c  output  CWIDTH  absorbed capacity, handed to the squeeze stage.
REQ-019 Port: absorb_done  output  1  one-cycle pulse; r and c are final.
REQ-020 Port: busy  output  1  high in every state except IDLE.

Function
REQ-021 FSM states: IDLE, LOAD, PADBLK, PERM, DONE; all outputs are registered, except that in_ready and perm_go decode directly from state.
REQ-022 IDLE, start=1: next-cycle actions:
- remaining <= msg_len
- r <= 0, c <= 0
- padded <= 0
- state <= LOAD if msg_len>0, else PADBLK.
REQ-023 IDLE, start=0: state and registers hold.
REQ-024 LOAD: in_ready=1. A word is accepted on the cycle where in_valid=1.
REQ-025 LOAD, word accepted, remaining>=RWIDTH:
- r <= r ^ in_data
- remaining <= remaining-RWIDTH
- state <= PERM.
REQ-026 LOAD, word accepted, 0<remaining<RWIDTH (k=remaining):
- padded word = in_data[k-1:0], bit k set to 1, bits above k zero (in_data bits >=k ignored)
- r <= r ^ padded word
- remaining <= 0, padded <= 1
- state <= PERM.
REQ-027 PADBLK (one cycle):
- r <= r ^ 1 (pad bit at bit 0)
- padded <= 1
- state <= PERM.
REQ-028 PERM: perm_go=1 and in_ready=0. State waits until perm_done=1.
REQ-029 PERM, perm_done=1: r <= perm_r_in and c <= perm_c_in; next state:
- DONE if padded=1
- else PADBLK if remaining=0
- else LOAD.
REQ-030 perm_go deasserts on the cycle after perm_done is sampled. perm_done is ignored outside PERM.
REQ-031 DONE: absorb_done=1 for exactly one cycle, then state <= IDLE.
REQ-032 r and c hold their final values in IDLE until the next accepted start.
REQ-033 start is ignored while busy=1.
REQ-034 remaining arithmetic is unsigned, REMAINWIDTH bits, and never underflows; the REQ-025/026 guard ensures this.
REQ-035 The number of permutations per message is floor(msg_len/RWIDTH)+1.

Reset
REQ-036 On reset=0, asynchronously:
- state = IDLE
- r = 0, c = 0
- remaining = 0, padded = 0
- in_ready = 0, perm_go = 0, absorb_done = 0, busy = 0.
REQ-037 Reset asserted mid-message (any state) aborts the message with no absorb_done pulse. After release the block waits for a new start.

Verification
REQ-038 msg_len=0, start, permutation model returns r=A5A5A5A5, c=0 -> perm_r_out=00000001 at the first perm_go; one permutation; absorb_done pulse; r=A5A5A5A5.
REQ-039 msg_len=8, in_data=FFFFFF3C, identity permutation -> r=0000013C; exactly one permutation; absorb_done.
REQ-040 msg_len=64, words 11111111 then 22222222, identity permutation -> three permutations; final r=33333333^00000001=33333332; in_ready=0 during each PERM.
REQ-041 in_valid withheld 5 cycles in LOAD -> in_ready stays 1, r unchanged; the word is absorbed on the first valid cycle.
REQ-042 perm_done delayed 20 cycles -> perm_go held high for all 20 cycles, low the cycle after perm_done; a spurious perm_done pulse in LOAD has no effect.
REQ-043 reset=0 during PERM of a 64-bit message -> all outputs zero immediately; no absorb_done. A new msg_len=8 run then completes correctly.

Source files
------------

// File: rtl/sponge_absorb.sv
// +--------------------------------------------------------------------------+
// | sponge_absorb: absorb phase of a sponge, one rate word per permutation   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module sponge_absorb #(
  parameter int CWIDTH      = 320,
  parameter int RWIDTH      = 32,
  parameter int REMAINWIDTH = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [REMAINWIDTH-1:0] msg_len,
  input  logic [RWIDTH-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   perm_go,
  output logic [RWIDTH-1:0]      perm_r_out,
  output logic [CWIDTH-1:0]      perm_c_out,
  input  logic [RWIDTH-1:0]      perm_r_in,
  input  logic [CWIDTH-1:0]      perm_c_in,
  input  logic                   perm_done,
  output logic [RWIDTH-1:0]      r,
  output logic [CWIDTH-1:0]      c,
  output logic                   absorb_done,
  output logic                   busy
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_LOAD   = 3'd1;
  localparam logic [2:0] c_PADBLK = 3'd2;
  localparam logic [2:0] c_PERM   = 3'd3;
  localparam logic [2:0] c_DONE   = 3'd4;

  localparam logic [RWIDTH-1:0]      c_ONE    = {{(RWIDTH-1){1'b0}}, 1'b1};
  localparam logic [REMAINWIDTH-1:0] c_RW_REM = REMAINWIDTH'(RWIDTH);

  logic [2:0]             r_state;
  logic [2:0]             w_state_nxt;
  logic [RWIDTH-1:0]      r_r;
  logic [CWIDTH-1:0]      r_c;
  logic [REMAINWIDTH-1:0] r_remaining;
  logic                   r_padded;
  logic                   r_absorb_done;
  logic                   r_busy;

  logic                   w_full;
  logic [RWIDTH-1:0]      w_pad_bit;
  logic [RWIDTH-1:0]      w_pad_mask;
  logic [RWIDTH-1:0]      w_pad_word;

  // A short word is only ever seen with 0 < remaining < RWIDTH, so the pad
  // bit always lands inside the rate word and remaining cannot underflow.
  assign w_full     = (r_remaining >= c_RW_REM);
  assign w_pad_bit  = c_ONE << r_remaining;
  assign w_pad_mask = w_pad_bit - c_ONE;
  assign w_pad_word = (in_data & w_pad_mask) | w_pad_bit;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (start) begin
          w_state_nxt = (msg_len != '0) ? c_LOAD : c_PADBLK;
        end
      end
      c_LOAD: begin
        if (in_valid) begin
          w_state_nxt = c_PERM;
        end
      end
      c_PADBLK: begin
        w_state_nxt = c_PERM;
      end
      c_PERM: begin
        if (perm_done) begin
          if (r_padded) begin
            w_state_nxt = c_DONE;
          end else if (r_remaining == '0) begin
            w_state_nxt = c_PADBLK;
          end else begin
            w_state_nxt = c_LOAD;
          end
        end
      end
      c_DONE: begin
        w_state_nxt = c_IDLE;
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= c_IDLE;
      r_r           <= '0;
      r_c           <= '0;
      r_remaining   <= '0;
      r_padded      <= 1'b0;
      r_absorb_done <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_absorb_done <= (w_state_nxt == c_DONE);
      r_busy        <= (w_state_nxt != c_IDLE);
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_remaining <= msg_len;
            r_r         <= '0;
            r_c         <= '0;
            r_padded    <= 1'b0;
          end
        end
        c_LOAD: begin
          if (in_valid) begin
            if (w_full) begin
              r_r         <= r_r ^ in_data;
              r_remaining <= r_remaining - c_RW_REM;
            end else begin
              r_r         <= r_r ^ w_pad_word;
              r_remaining <= '0;
              r_padded    <= 1'b1;
            end
          end
        end
        c_PADBLK: begin
          r_r      <= r_r ^ c_ONE;
          r_padded <= 1'b1;
        end
        c_PERM: begin
          if (perm_done) begin
            r_r <= perm_r_in;
            r_c <= perm_c_in;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready    = (r_state == c_LOAD);
  assign perm_go     = (r_state == c_PERM);
  assign perm_r_out  = r_r;
  assign perm_c_out  = r_c;
  assign r           = r_r;
  assign c           = r_c;
  assign absorb_done = r_absorb_done;
  assign busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_sponge_absorb.sv
// +--------------------------------------------------------------------------+
// | tb_sponge_absorb: scoreboard bench for sponge_absorb                     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sponge_absorb;

  localparam int CW = 320;
  localparam int RW = 32;
  localparam int LW = 20;
  localparam logic [CW-1:0] C_PAT = {10{32'hC0FFEE01}};

  logic          clk;
  logic          reset;
  logic          start;
  logic [LW-1:0] msg_len;
  logic [RW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          perm_go;
  logic [RW-1:0] perm_r_out;
  logic [CW-1:0] perm_c_out;
  logic [RW-1:0] perm_r_in;
  logic [CW-1:0] perm_c_in;
  logic          perm_done;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic          absorb_done;
  logic          busy;

  logic pd_resp;
  logic pd_spur;
  assign perm_done = pd_resp | pd_spur;

  sponge_absorb #(.CWIDTH(CW), .RWIDTH(RW), .REMAINWIDTH(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .msg_len(msg_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .perm_go(perm_go), .perm_r_out(perm_r_out), .perm_c_out(perm_c_out),
    .perm_r_in(perm_r_in), .perm_c_in(perm_c_in), .perm_done(perm_done),
    .r(r), .c(c), .absorb_done(absorb_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [RW-1:0] r; logic [CW-1:0] c; } perm_exp_t;
  typedef struct { logic [RW-1:0] r; logic [CW-1:0] c; int n; } fin_exp_t;

  perm_exp_t perm_q[$];
  fin_exp_t  fin_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int perm_mode  = 1;   // 0: constant A5A5A5A5, 1: identity, 2: identity with c ^= C_PAT
  int perm_delay = 0;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Permutation model
  initial begin
    pd_resp   = 1'b0;
    perm_r_in = '0;
    perm_c_in = '0;
    forever begin
      @(negedge clk);
      if (reset && perm_go) begin
        automatic bit ok = 1'b1;
        for (int i = 0; i < perm_delay; i++) begin
          @(negedge clk);
          if (!reset) begin
            ok = 1'b0;
            break;
          end
          chk("perm_go_held", CW'(perm_go), CW'(1'b1));
        end
        if (ok) begin
          case (perm_mode)
            0:       begin perm_r_in = 32'hA5A5A5A5; perm_c_in = '0; end
            2:       begin perm_r_in = perm_r_out;   perm_c_in = perm_c_out ^ C_PAT; end
            default: begin perm_r_in = perm_r_out;   perm_c_in = perm_c_out; end
          endcase
          pd_resp = 1'b1;
          @(negedge clk);
          pd_resp = 1'b0;
          chk("perm_go_drop", CW'(perm_go), CW'(1'b0));
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a request or a result
  initial begin
    automatic logic prev_go = 1'b0;
    automatic int   pcount  = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_go = 1'b0;
        pcount  = 0;
      end else begin
        if (perm_go && !prev_go) begin
          pcount++;
          chk("in_ready_in_perm", CW'(in_ready), CW'(1'b0));
          if (perm_q.size() == 0) begin
            chk("perm_unexpected", CW'(1'b1), CW'(1'b0));
          end else begin
            automatic perm_exp_t e = perm_q.pop_front();
            chk("perm_r_out", CW'(perm_r_out), CW'(e.r));
            chk("perm_c_out", perm_c_out, e.c);
          end
        end
        if (absorb_done) begin
          chk("busy_in_done", CW'(busy), CW'(1'b1));
          if (fin_q.size() == 0) begin
            chk("absorb_done_unexpected", CW'(1'b1), CW'(1'b0));
          end else begin
            automatic fin_exp_t f = fin_q.pop_front();
            chk("final_r", CW'(r), CW'(f.r));
            chk("final_c", c, f.c);
            chk("perm_count", CW'(pcount), CW'(f.n));
          end
          pcount = 0;
        end
        prev_go = perm_go;
      end
    end
  end

  task automatic push_perm(input logic [RW-1:0] er, input logic [CW-1:0] ec);
    perm_exp_t e;
    e.r = er; e.c = ec;
    perm_q.push_back(e);
  endtask

  task automatic push_fin(input logic [RW-1:0] er, input logic [CW-1:0] ec, input int n);
    fin_exp_t f;
    f.r = er; f.c = ec; f.n = n;
    fin_q.push_back(f);
  endtask

  task automatic do_start(input logic [LW-1:0] len);
    start   = 1'b1;
    msg_len = len;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", CW'(busy), CW'(1'b1));
  endtask

  task automatic send_word(input logic [RW-1:0] d);
    int t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", CW'(in_ready), CW'(1'b1));
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 32'hDEADBEEF;
  endtask

  task automatic wait_done(input logic [RW-1:0] final_r);
    int t = 0;
    while (!absorb_done && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("absorb_done_seen", CW'(absorb_done), CW'(1'b1));
    repeat (3) @(negedge clk);
    chk("idle_busy", CW'(busy), CW'(1'b0));
    chk("idle_r_held", CW'(r), CW'(final_r));
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    msg_len  = '0;
    in_data  = '0;
    in_valid = 1'b0;
    pd_spur  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_r", CW'(r), '0);
    chk("rst_c", c, '0);
    chk("rst_ctrl", CW'({in_ready, perm_go, absorb_done, busy}), '0);
    reset = 1'b1;
    @(negedge clk);

    // Empty message: pad-only block, constant permutation result
    perm_mode = 0;
    push_perm(32'h00000001, '0);
    push_fin(32'hA5A5A5A5, '0, 1);
    do_start(20'd0);
    wait_done(32'hA5A5A5A5);

    // 8-bit message: upper input bits ignored, pad at bit 8
    perm_mode = 1;
    push_perm(32'h0000013C, '0);
    push_fin(32'h0000013C, '0, 1);
    do_start(20'd8);
    send_word(32'hFFFFFF3C);
    wait_done(32'h0000013C);

    // 64-bit message: two full words plus a pad-only block; start while busy ignored
    push_perm(32'h11111111, '0);
    push_perm(32'h33333333, '0);
    push_perm(32'h33333332, '0);
    push_fin(32'h33333332, '0, 3);
    do_start(20'd64);
    send_word(32'h11111111);
    start   = 1'b1;
    msg_len = 20'd0;
    @(negedge clk);
    start = 1'b0;
    send_word(32'h22222222);
    wait_done(32'h33333332);

    // 40-bit message: valid withheld, spurious perm_done, slow permutation
    perm_delay = 20;
    push_perm(32'hAAAAAAAA, '0);
    push_perm(32'hAAAAABD2, '0);
    push_fin(32'hAAAAABD2, '0, 2);
    do_start(20'd40);
    for (int i = 0; i < 5; i++) begin
      chk("withheld_in_ready", CW'(in_ready), CW'(1'b1));
      chk("withheld_r", CW'(perm_r_out), '0);
      pd_spur = (i == 1);
      @(negedge clk);
    end
    pd_spur = 1'b0;
    send_word(32'hAAAAAAAA);
    send_word(32'h12345678);
    wait_done(32'hAAAAABD2);

    // Reset asserted while a permutation is pending
    perm_delay = 10;
    push_perm(32'h11111111, '0);
    do_start(20'd64);
    send_word(32'h11111111);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_r", CW'(r), '0);
    chk("abort_c", c, '0);
    chk("abort_ctrl", CW'({in_ready, perm_go, absorb_done, busy}), '0);
    chk("abort_perm_q", CW'(perm_q.size()), '0);
    perm_q.delete();
    fin_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_abort_idle", CW'({absorb_done, busy}), '0);

    // Fresh 8-bit message after the abort, capacity path exercised
    perm_delay = 0;
    perm_mode  = 2;
    push_perm(32'h000001A5, '0);
    push_fin(32'h000001A5, C_PAT, 1);
    do_start(20'd8);
    send_word(32'h000000A5);
    wait_done(32'h000001A5);

    chk("perm_q_drained", CW'(perm_q.size()), '0);
    chk("fin_q_drained", CW'(fin_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
